// File: rtl/order_price_update_ctrl.sv
// Read-modify-write controller for a price-level book RAM (ADD/CANCEL/QUERY/CLEAR).
// Optional ORDER_PRICE_CLEAR_ON_RESET_EN: zero the whole RAM after reset before accepting requests.
//
// state  | meaning
// INIT   | clearing RAM, one address per cycle (only with ORDER_PRICE_CLEAR_ON_RESET_EN)
// IDLE   | req_ready high, waiting for a request
// LOOKUP | RAM address driven with the latched index
// CALC   | RAM data valid; new entry and error flag registered
// WRITE  | write-back pulse when the operation changed the entry
// RESP   | response held until resp_ready
module order_price_update_ctrl #(
  parameter int ADDR_W = 12,
  parameter int QTY_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                        axis_aclk,
  input  logic                        axis_resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [ADDR_W-1:0]           req_idx,
  input  logic [QTY_W-1:0]            req_qty,
  input  logic [183-QTY_W-CNT_W-1:0]  req_content,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [182:0]                ram_din,
  output logic                        ram_we,
  input  logic [182:0]                ram_dout,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [182:0]                resp_entry,
  output logic                        resp_err
);

  localparam int EW = 183;
  localparam int CW = EW - QTY_W - CNT_W;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_CANCEL = 2'b01;
  localparam logic [1:0] OP_QUERY  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

`ifdef ORDER_PRICE_CLEAR_ON_RESET_EN
  localparam logic [2:0] INIT   = 3'd0;
`endif
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] LOOKUP = 3'd2;
  localparam logic [2:0] CALC   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [QTY_W-1:0]  qty_q;
  logic [CW-1:0]     content_q;
  logic [EW-1:0]     entry_q;
  logic              err_q;
  logic              ram_we_q;
`ifdef ORDER_PRICE_CLEAR_ON_RESET_EN
  logic [ADDR_W:0]   clr_cnt;
`endif

  logic [QTY_W-1:0]  cur_qty;
  logic [CNT_W-1:0]  cur_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_dec;
  logic [QTY_W:0]    qty_sum;
  logic [EW-1:0]     calc_entry;
  logic              calc_err;
  logic              calc_wr;

  always_comb begin
    cur_qty    = ram_dout[EW-1 -: QTY_W];
    cur_cnt    = ram_dout[CW +: CNT_W];
    cnt_inc    = cur_cnt + CNT_W'(1);
    cnt_dec    = cur_cnt - CNT_W'(1);
    qty_sum    = {1'b0, cur_qty} + {1'b0, qty_q};
    calc_entry = ram_dout;
    calc_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        if (qty_sum[QTY_W] || (&cur_cnt)) calc_err = 1'b1;
        else calc_entry = {qty_sum[QTY_W-1:0], cnt_inc, content_q};
      end
      OP_CANCEL: begin
        if ((cur_qty >= qty_q) && (cur_cnt != '0))
          calc_entry = {cur_qty - qty_q, cnt_dec, ram_dout[CW-1:0]};
        else calc_err = 1'b1;
      end
      OP_CLEAR: calc_entry = '0;
      default: ;
    endcase
    calc_wr = !calc_err && (op_q != OP_QUERY);
  end

  // Gated by the reset input so a reset arriving during WRITE suppresses that cycle's write.
  assign ram_we = ram_we_q & axis_resetn;

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
`ifdef ORDER_PRICE_CLEAR_ON_RESET_EN
      state   <= INIT;
      clr_cnt <= '0;
`else
      state   <= IDLE;
`endif
      op_q       <= '0;
      qty_q      <= '0;
      content_q  <= '0;
      entry_q    <= '0;
      err_q      <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_entry <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
`ifdef ORDER_PRICE_CLEAR_ON_RESET_EN
        INIT: begin
          if (!clr_cnt[ADDR_W]) begin
            ram_we_q <= 1'b1;
            ram_addr <= clr_cnt[ADDR_W-1:0];
            ram_din  <= '0;
            clr_cnt  <= clr_cnt + 1'b1;
          end else begin
            ram_we_q  <= 1'b0;
            ram_addr  <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        IDLE: begin
          if (req_ready && req_valid) begin
            op_q      <= req_op;
            qty_q     <= req_qty;
            content_q <= req_content;
            ram_addr  <= req_idx;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOOKUP: state <= CALC;
        CALC: begin
          entry_q  <= calc_entry;
          err_q    <= calc_err;
          ram_din  <= calc_entry;
          ram_we_q <= calc_wr;
          state    <= WRITE;
        end
        WRITE: begin
          ram_we_q   <= 1'b0;
          resp_valid <= 1'b1;
          resp_entry <= entry_q;
          resp_err   <= err_q;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          ram_we_q  <= 1'b0;
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_price_update_ctrl.sv
// Directed bench for order_price_update_ctrl (default build) with a behavioural 1-cycle-latency RAM.
module tb_order_price_update_ctrl;

  localparam int CW = 135;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [11:0]   req_idx;
  logic [31:0]   req_qty;
  logic [CW-1:0] req_content;
  logic [11:0]   ram_addr;
  logic [182:0]  ram_din;
  logic          ram_we;
  logic [182:0]  ram_dout;
  logic          resp_valid;
  logic          resp_ready;
  logic [182:0]  resp_entry;
  logic          resp_err;

  logic [182:0]  mem [0:4095];
  int            wr_count = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  order_price_update_ctrl dut (
    .axis_aclk   (clk),
    .axis_resetn (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_idx     (req_idx),
    .req_qty     (req_qty),
    .req_content (req_content),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_entry  (resp_entry),
    .resp_err    (resp_err)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_count <= wr_count + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [182:0] obs, input logic [182:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and samples the RAM port at T+3 and the response at T+4.
  task automatic send(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] qty,
                      input logic [CW-1:0] content, output logic we3, output logic [11:0] addr3,
                      output logic [182:0] din3, output logic [182:0] entry, output logic err,
                      output logic vld);
    for (int i = 0; i < 20 && !req_ready; i++) step();
    chk("ready_before_req", 183'(req_ready), 183'(1'b1));
    req_valid   = 1'b1;
    req_op      = op;
    req_idx     = idx;
    req_qty     = qty;
    req_content = content;
    step();
    req_valid = 1'b0;
    chk("lookup_addr", 183'(ram_addr), 183'(idx));
    chk("lookup_we", 183'(ram_we), 183'(1'b0));
    step();
    chk("calc_we", 183'(ram_we), 183'(1'b0));
    step();
    we3   = ram_we;
    addr3 = ram_addr;
    din3  = ram_din;
    step();
    vld   = resp_valid;
    entry = resp_entry;
    err   = resp_err;
  endtask

  logic [CW-1:0] c1, c2, c3, c4;
  logic          we3, err, vld;
  logic [11:0]   addr3;
  logic [182:0]  din3, entry;
  int            wr_before;

  initial begin
    c1 = 135'h12_3456_789a_bcde_f011_2233_4455_6677_8899;
    c2 = 135'h7f_0000_1111_2222_3333_4444_5555_6666_7777;
    c3 = 135'h01_a5a5_a5a5_a5a5_a5a5_a5a5_a5a5_a5a5_a5a5;
    c4 = 135'h55_dead_beef_cafe_f00d_0123_4567_89ab_cdef;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[9]  = {32'hFFFF_FFFF, 16'd3, c2};
    mem[10] = {32'd5, 16'hFFFF, c1};
    mem[11] = {32'hFFFF_FFF0, 16'd2, c3};
    ram_dout    = '0;
    resetn      = 1'b0;
    req_valid   = 1'b1;
    req_op      = 2'b00;
    req_idx     = 12'd7;
    req_qty     = 32'd9;
    req_content = c1;
    resp_ready  = 1'b1;

    repeat (3) step();
    chk("rst_req_ready", 183'(req_ready), 183'(1'b0));
    chk("rst_resp_valid", 183'(resp_valid), 183'(1'b0));
    chk("rst_resp_err", 183'(resp_err), 183'(1'b0));
    chk("rst_resp_entry", resp_entry, 183'(0));
    chk("rst_ram_we", 183'(ram_we), 183'(1'b0));
    chk("rst_ram_addr", 183'(ram_addr), 183'(0));
    chk("rst_ram_din", ram_din, 183'(0));
    req_valid = 1'b0;
    resetn    = 1'b1;
    step();
    chk("ready_after_release", 183'(req_ready), 183'(1'b1));

    // ADD to an empty level
    wr_before = wr_count;
    send(2'b00, 12'd5, 32'd100, c1, we3, addr3, din3, entry, err, vld);
    chk("add_we", 183'(we3), 183'(1'b1));
    chk("add_addr", 183'(addr3), 183'(12'd5));
    chk("add_din", din3, {32'd100, 16'd1, c1});
    chk("add_resp_valid", 183'(vld), 183'(1'b1));
    chk("add_resp_entry", entry, {32'd100, 16'd1, c1});
    chk("add_resp_err", 183'(err), 183'(1'b0));
    step();
    chk("add_ready_t5", 183'(req_ready), 183'(1'b1));
    chk("add_single_write", 183'(wr_count - wr_before), 183'(1));

    // CANCEL larger than resting quantity
    send(2'b01, 12'd5, 32'd150, c2, we3, addr3, din3, entry, err, vld);
    chk("cxl_big_we", 183'(we3), 183'(1'b0));
    chk("cxl_big_err", 183'(err), 183'(1'b1));
    chk("cxl_big_entry", entry, {32'd100, 16'd1, c1});

    // CANCEL partial, content kept, count to zero
    send(2'b01, 12'd5, 32'd40, c2, we3, addr3, din3, entry, err, vld);
    chk("cxl_we", 183'(we3), 183'(1'b1));
    chk("cxl_din", din3, {32'd60, 16'd0, c1});
    chk("cxl_err", 183'(err), 183'(1'b0));

    // CANCEL with count already zero
    send(2'b01, 12'd5, 32'd0, c2, we3, addr3, din3, entry, err, vld);
    chk("cxl_cnt0_err", 183'(err), 183'(1'b1));
    chk("cxl_cnt0_we", 183'(we3), 183'(1'b0));
    chk("cxl_cnt0_entry", entry, {32'd60, 16'd0, c1});

    // ADD overflowing quantity, then QUERY
    send(2'b00, 12'd9, 32'd1, c4, we3, addr3, din3, entry, err, vld);
    chk("add_ovf_err", 183'(err), 183'(1'b1));
    chk("add_ovf_we", 183'(we3), 183'(1'b0));
    chk("add_ovf_entry", entry, {32'hFFFF_FFFF, 16'd3, c2});
    send(2'b10, 12'd9, 32'd0, c4, we3, addr3, din3, entry, err, vld);
    chk("query_we", 183'(we3), 183'(1'b0));
    chk("query_err", 183'(err), 183'(1'b0));
    chk("query_entry", entry, {32'hFFFF_FFFF, 16'd3, c2});

    // ADD with order count saturated
    send(2'b00, 12'd10, 32'd1, c4, we3, addr3, din3, entry, err, vld);
    chk("add_cntmax_err", 183'(err), 183'(1'b1));
    chk("add_cntmax_we", 183'(we3), 183'(1'b0));

    // ADD landing exactly on the maximum quantity
    send(2'b00, 12'd11, 32'h0000_000F, c4, we3, addr3, din3, entry, err, vld);
    chk("add_edge_err", 183'(err), 183'(1'b0));
    chk("add_edge_din", din3, {32'hFFFF_FFFF, 16'd3, c4});

    // CLEAR
    send(2'b11, 12'd11, 32'd77, c4, we3, addr3, din3, entry, err, vld);
    chk("clr_we", 183'(we3), 183'(1'b1));
    chk("clr_addr", 183'(addr3), 183'(12'd11));
    chk("clr_din", din3, 183'(0));
    chk("clr_entry", entry, 183'(0));
    chk("clr_err", 183'(err), 183'(1'b0));
    step();
    chk("clr_mem", mem[11], 183'(0));

    // Response back-pressure
    resp_ready = 1'b0;
    send(2'b10, 12'd5, 32'd0, c4, we3, addr3, din3, entry, err, vld);
    chk("hold_first_valid", 183'(vld), 183'(1'b1));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 183'(resp_valid), 183'(1'b1));
      chk("hold_entry", resp_entry, {32'd60, 16'd0, c1});
      chk("hold_ready", 183'(req_ready), 183'(1'b0));
    end
    resp_ready = 1'b1;
    step();
    chk("hold_release_valid", 183'(resp_valid), 183'(1'b0));
    chk("hold_release_ready", 183'(req_ready), 183'(1'b1));

    // Reset pulsed while in WRITE
    wr_before   = wr_count;
    req_valid   = 1'b1;
    req_op      = 2'b00;
    req_idx     = 12'd20;
    req_qty     = 32'd7;
    req_content = c1;
    step();
    req_valid = 1'b0;
    step();
    step();
    resetn = 1'b0;
    #1;
    chk("rst_write_we", 183'(ram_we), 183'(1'b0));
    step();
    chk("rst_write_valid", 183'(resp_valid), 183'(1'b0));
    resetn = 1'b1;
    step();
    chk("rst_write_ready", 183'(req_ready), 183'(1'b1));
    repeat (5) step();
    chk("rst_write_no_resp", 183'(resp_valid), 183'(1'b0));
    chk("rst_write_no_wr", 183'(wr_count - wr_before), 183'(0));
    chk("rst_write_mem", mem[20], 183'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/order_price_update_ctrl.md
ORDER_PRICE_UPDATE_CTRL -- requirements
Module: order_price_update_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning price-level index width (4096 levels).
REQ-002 The block SHALL have parameter QTY_W, default 32, meaning aggregate quantity field width.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning order-count field width; content field width CW = 183 - QTY_W - CNT_W (135 at defaults).
REQ-004 The block SHALL have the following ports:
axis_aclk  in  1  sole clock
axis_resetn  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when high with req_valid
req_op  in  2  00 ADD, 01 CANCEL, 10 QUERY, 11 CLEAR
req_idx  in  ADDR_W  price-level index
req_qty  in  QTY_W  order quantity
req_content  in  CW  order content payload
ram_addr  out  ADDR_W  price-RAM address
ram_din  out  183  price-RAM write data
ram_we  out  1  price-RAM write enable
ram_dout  in  183  price-RAM read data, 1-cycle registered latency
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_entry  out  183  post-operation entry
resp_err  out  1  operation rejected

Function
REQ-005 Entry layout SHALL be {qty[QTY_W], cnt[CNT_W], content[CW]}, qty at MSBs.
REQ-006 FSM states SHALL be INIT, IDLE, LOOKUP, CALC, WRITE, RESP.
REQ-007 req_ready SHALL be high only in IDLE; one request is in flight at a time.
REQ-008 On acceptance (cycle T) the block SHALL latch op/idx/qty/content and enter LOOKUP; ram_addr SHALL equal req_idx in T+1 with ram_we=0.
REQ-009 In CALC (T+2) the block SHALL sample ram_dout and register the new entry and error flag.
REQ-010 ADD: qty+req_qty, cnt+1, content=req_content; on qty overflow or cnt at max, the entry SHALL be left unchanged and err=1.
REQ-011 CANCEL: if qty>=req_qty and cnt>0, qty-req_qty and cnt-1, content unchanged; else entry unchanged and err=1.
REQ-012 QUERY SHALL leave the entry unchanged with err=0; CLEAR SHALL produce an all-zero entry with err=0.
REQ-013 WRITE (T+3) SHALL assert ram_we=1 for exactly one cycle with ram_din=new entry, only for ADD/CANCEL/CLEAR with err=0; otherwise ram_we=0.
REQ-014 RESP (from T+4) SHALL hold resp_valid=1 with stable resp_entry/resp_err until resp_ready; then IDLE next cycle.
REQ-015 Minimum request-to-request spacing SHALL be 5 cycles with resp_ready held high.
REQ-016 ram_we SHALL be 0 in every state except WRITE and INIT.

Reset
REQ-017 While axis_resetn=0 at a clock edge: req_ready=0, resp_valid=0, resp_err=0, resp_entry=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-018 Reset asserted mid-operation SHALL abort it with no RAM write issued and no response produced.
REQ-019 After reset release the FSM SHALL enter INIT if ORDER_PRICE_CLEAR_ON_RESET_EN is defined, else IDLE.

Configuration
REQ-020 Macro ORDER_PRICE_CLEAR_ON_RESET_EN defined: INIT SHALL write zero to addresses 0..4095 ascending, one per cycle (ram_we=1), then enter IDLE; req_ready=0 throughout (4096 cycles).
REQ-021 Macro not defined: INIT SHALL be absent; req_ready SHALL rise the first cycle after reset release and RAM contents are not cleared.

Verification
REQ-022 With macro defined, release reset -> 4096 consecutive ram_we pulses, addr 0..4095, din=0; req_ready high cycle 4097.
REQ-023 ADD idx=5 qty=100 to zero entry -> ram_we at T+3 addr 5, din qty=100 cnt=1; resp err=0.
REQ-024 CANCEL idx=5 qty=150 on qty=100 -> no ram_we, resp_err=1, resp_entry qty=100 cnt=1.
REQ-025 ADD qty=1 on qty=0xFFFFFFFF -> no write, resp_err=1; QUERY afterwards returns unchanged entry.
REQ-026 resp_ready held low 10 cycles -> resp_valid/resp_entry stable, req_ready=0; reset pulsed in WRITE state -> ram_we=0 that cycle, no response.
